rob: RTL and testbench

//  Reorder buffer: circular queue of in-flight instructions, allocated in program order at decode.

---
 rtl/rob_if.sv | 53 +++++
 rtl/rob.sv | 154 +++++++++++++++
 tb/tb_rob.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/rob_if.sv
// Reorder-buffer bus: decoder allocation, operand lookup, RS/LSB result broadcasts, commit and flush.
// master = decoder/RS/LSB side, slave = reorder buffer.
interface rob_if #(parameter int ROB_SIZE = 16);
  localparam int ROB_W = $clog2(ROB_SIZE);

  logic             dc_alloc;
  logic [1:0]       dc_kind;
  logic [4:0]       dc_rd;
  logic             dc_pred_taken;
  logic [31:0]      dc_pred_pc;
  logic             rob_full;
  logic [ROB_W-1:0] rob_tail_id;
  logic [ROB_W-1:0] qry1_id;
  logic [ROB_W-1:0] qry2_id;
  logic             qry1_rdy;
  logic             qry2_rdy;
  logic [31:0]      qry1_val;
  logic [31:0]      qry2_val;
  logic             rs_has_output;
  logic [ROB_W-1:0] rs_rob_id;
  logic [31:0]      rs_output;
  logic [31:0]      jalr_new_pc;
  logic             is_lsb;
  logic [ROB_W-1:0] lsb_rob_id;
  logic [31:0]      lsb_res;
  logic             commit_valid;
  logic [ROB_W-1:0] commit_rob_id;
  logic [4:0]       commit_rd;
  logic [31:0]      commit_val;
  logic             commit_store;
  logic             rob_clear;
  logic [31:0]      rob_new_pc;

  modport master (
    output dc_alloc, dc_kind, dc_rd, dc_pred_taken, dc_pred_pc,
    output qry1_id, qry2_id,
    output rs_has_output, rs_rob_id, rs_output, jalr_new_pc,
    output is_lsb, lsb_rob_id, lsb_res,
    input  rob_full, rob_tail_id, qry1_rdy, qry2_rdy, qry1_val, qry2_val,
    input  commit_valid, commit_rob_id, commit_rd, commit_val, commit_store,
    input  rob_clear, rob_new_pc
  );

  modport slave (
    input  dc_alloc, dc_kind, dc_rd, dc_pred_taken, dc_pred_pc,
    input  qry1_id, qry2_id,
    input  rs_has_output, rs_rob_id, rs_output, jalr_new_pc,
    input  is_lsb, lsb_rob_id, lsb_res,
    output rob_full, rob_tail_id, qry1_rdy, qry2_rdy, qry1_val, qry2_val,
    output commit_valid, commit_rob_id, commit_rd, commit_val, commit_store,
    output rob_clear, rob_new_pc
  );
endinterface

// File: rtl/rob.sv
// Reorder buffer: in-order alloc, out-of-order result writes, in-order commit with mispredict flush.
// Latency: commit/flush outputs registered one edge after head is ready; queries combinational.
// Backpressure: rdy_in=0 freezes all state; decoder must not alloc while rob_full. Option: ROB_BYPASS_EN.
module rob #(
  parameter int ROB_SIZE = 16
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rdy_in,
  rob_if.slave bus
);
  localparam int ROB_W = $clog2(ROB_SIZE);
  localparam logic [1:0] KIND_ALU    = 2'd0;
  localparam logic [1:0] KIND_BRANCH = 2'd1;
  localparam logic [1:0] KIND_JALR   = 2'd2;
  localparam logic [1:0] KIND_STORE  = 2'd3;

  typedef logic [ROB_W-1:0] id_t;
  typedef logic [ROB_W:0]   cnt_t;

  typedef struct packed {
    logic        busy;
    logic        ready;
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic [31:0] value;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic [31:0] real_pc;
  } entry_t;

  entry_t      ent_q [ROB_SIZE];
  id_t         head_q, tail_q;
  cnt_t        count_q;
  logic        commit_valid_q, commit_store_q, rob_clear_q;
  id_t         commit_rob_id_q;
  logic [4:0]  commit_rd_q;
  logic [31:0] commit_val_q, rob_new_pc_q;

  entry_t head_ent;
  logic   commit_fire, mispredict, flush, alloc_fire;

  always_comb begin
    head_ent    = ent_q[head_q];
    commit_fire = rdy_in && head_ent.busy && head_ent.ready;
    mispredict  = 1'b0;
    case (head_ent.kind)
      KIND_BRANCH: mispredict = (head_ent.value[0] != head_ent.pred_taken) ||
                                (head_ent.real_pc != head_ent.pred_pc);
      KIND_JALR:   mispredict = (head_ent.real_pc != head_ent.pred_pc);
      default:     mispredict = 1'b0;
    endcase
    flush = commit_fire && mispredict;
    // Allocs are dropped while a flush is being taken or broadcast; a full ROB accepts one only alongside a commit.
    alloc_fire = rdy_in && bus.dc_alloc && !flush && !rob_clear_q &&
                 ((count_q != cnt_t'(ROB_SIZE)) || commit_fire);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < ROB_SIZE; i++) ent_q[i] <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      commit_valid_q  <= 1'b0;
      commit_store_q  <= 1'b0;
      commit_rob_id_q <= '0;
      commit_rd_q     <= '0;
      commit_val_q    <= '0;
      rob_clear_q     <= 1'b0;
      rob_new_pc_q    <= '0;
    end else if (rdy_in) begin
      commit_valid_q <= commit_fire;
      commit_store_q <= commit_fire && (head_ent.kind == KIND_STORE);
      rob_clear_q    <= flush;
      if (commit_fire) begin
        commit_rob_id_q      <= head_q;
        commit_rd_q          <= (head_ent.kind == KIND_ALU || head_ent.kind == KIND_JALR) ? head_ent.rd : 5'd0;
        commit_val_q         <= head_ent.value;
        ent_q[head_q].busy   <= 1'b0;
        head_q               <= head_q + id_t'(1);
      end
      if (flush) rob_new_pc_q <= head_ent.real_pc;
      if (bus.rs_has_output && ent_q[bus.rs_rob_id].busy) begin
        ent_q[bus.rs_rob_id].ready   <= 1'b1;
        ent_q[bus.rs_rob_id].value   <= bus.rs_output;
        ent_q[bus.rs_rob_id].real_pc <= bus.jalr_new_pc;
      end
      if (bus.is_lsb && ent_q[bus.lsb_rob_id].busy) begin
        ent_q[bus.lsb_rob_id].ready <= 1'b1;
        ent_q[bus.lsb_rob_id].value <= bus.lsb_res;
      end
      // Placed after the commit clear so a full-ROB alloc into the just-freed head slot wins.
      if (alloc_fire) begin
        ent_q[tail_q] <= '{busy: 1'b1, ready: 1'b0, kind: bus.dc_kind, rd: bus.dc_rd,
                           value: 32'd0, pred_taken: bus.dc_pred_taken,
                           pred_pc: bus.dc_pred_pc, real_pc: 32'd0};
        tail_q <= tail_q + id_t'(1);
      end
      count_q <= count_q + cnt_t'(alloc_fire) - cnt_t'(commit_fire);
      if (flush) begin
        for (int i = 0; i < ROB_SIZE; i++) ent_q[i].busy <= 1'b0;
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end
    end else begin
      commit_valid_q <= 1'b0;
      commit_store_q <= 1'b0;
      rob_clear_q    <= 1'b0;
    end
  end

`ifdef ROB_BYPASS_EN
  // RS broadcast is applied last so it overrides a same-id LSB broadcast.
  always_comb begin
    bus.qry1_rdy = ent_q[bus.qry1_id].busy && ent_q[bus.qry1_id].ready;
    bus.qry1_val = ent_q[bus.qry1_id].value;
    bus.qry2_rdy = ent_q[bus.qry2_id].busy && ent_q[bus.qry2_id].ready;
    bus.qry2_val = ent_q[bus.qry2_id].value;
    if (bus.is_lsb && bus.lsb_rob_id == bus.qry1_id) begin
      bus.qry1_rdy = 1'b1;
      bus.qry1_val = bus.lsb_res;
    end
    if (bus.is_lsb && bus.lsb_rob_id == bus.qry2_id) begin
      bus.qry2_rdy = 1'b1;
      bus.qry2_val = bus.lsb_res;
    end
    if (bus.rs_has_output && bus.rs_rob_id == bus.qry1_id) begin
      bus.qry1_rdy = 1'b1;
      bus.qry1_val = bus.rs_output;
    end
    if (bus.rs_has_output && bus.rs_rob_id == bus.qry2_id) begin
      bus.qry2_rdy = 1'b1;
      bus.qry2_val = bus.rs_output;
    end
  end
`else
  assign bus.qry1_rdy = ent_q[bus.qry1_id].busy && ent_q[bus.qry1_id].ready;
  assign bus.qry1_val = ent_q[bus.qry1_id].value;
  assign bus.qry2_rdy = ent_q[bus.qry2_id].busy && ent_q[bus.qry2_id].ready;
  assign bus.qry2_val = ent_q[bus.qry2_id].value;
`endif

  assign bus.rob_full      = (count_q == cnt_t'(ROB_SIZE));
  assign bus.rob_tail_id   = tail_q;
  assign bus.commit_valid  = commit_valid_q;
  assign bus.commit_rob_id = commit_rob_id_q;
  assign bus.commit_rd     = commit_rd_q;
  assign bus.commit_val    = commit_val_q;
  assign bus.commit_store  = commit_store_q;
  assign bus.rob_clear     = rob_clear_q;
  assign bus.rob_new_pc    = rob_new_pc_q;
endmodule

// File: tb/tb_rob.sv
// Scoreboard bench for rob: directed stimulus pushes expected commits, a negedge monitor pops and compares.
module tb_rob;
  localparam int ROB_SIZE = 16;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b0;

  rob_if #(.ROB_SIZE(ROB_SIZE)) bus ();
  rob #(.ROB_SIZE(ROB_SIZE)) dut (.clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .bus(bus));

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [3:0]  id;
    logic [4:0]  rd;
    logic [31:0] val;
    logic        chk_val;
    logic        store;
    logic        clear;
    logic [31:0] new_pc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  task automatic expect_commit(input logic [3:0] id, input logic [4:0] rd, input logic [31:0] val,
                               input logic chk_val, input logic store, input logic clear,
                               input logic [31:0] new_pc);
    exp_q.push_back('{id, rd, val, chk_val, store, clear, new_pc});
  endtask

  // Monitor: every commit/clear pulse must match the oldest expectation.
  always @(negedge clk_in) begin
    if (rst_in && (bus.commit_valid || bus.rob_clear)) begin
      if (!bus.commit_valid) check("clear_without_commit", 32'(bus.rob_clear), 32'd0);
      else if (exp_q.size() == 0) check("unexpected_commit", 32'(bus.commit_valid), 32'd0);
      else begin
        mon_e = exp_q.pop_front();
        check("commit_rob_id", 32'(bus.commit_rob_id), 32'(mon_e.id));
        check("commit_rd", 32'(bus.commit_rd), 32'(mon_e.rd));
        if (mon_e.chk_val) check("commit_val", bus.commit_val, mon_e.val);
        check("commit_store", 32'(bus.commit_store), 32'(mon_e.store));
        check("rob_clear", 32'(bus.rob_clear), 32'(mon_e.clear));
        if (mon_e.clear) check("rob_new_pc", bus.rob_new_pc, mon_e.new_pc);
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    bus.dc_alloc = 0; bus.dc_kind = 0; bus.dc_rd = 0; bus.dc_pred_taken = 0; bus.dc_pred_pc = 0;
    bus.qry1_id = 0; bus.qry2_id = 0;
    bus.rs_has_output = 0; bus.rs_rob_id = 0; bus.rs_output = 0; bus.jalr_new_pc = 0;
    bus.is_lsb = 0; bus.lsb_rob_id = 0; bus.lsb_res = 0;
  endtask

  task automatic alloc(input logic [1:0] kind, input logic [4:0] rd, input logic pt, input logic [31:0] ppc);
    bus.dc_alloc = 1; bus.dc_kind = kind; bus.dc_rd = rd; bus.dc_pred_taken = pt; bus.dc_pred_pc = ppc;
    step();
    bus.dc_alloc = 0;
  endtask

  task automatic rs_bcast(input logic [3:0] id, input logic [31:0] val, input logic [31:0] pc);
    bus.rs_has_output = 1; bus.rs_rob_id = id; bus.rs_output = val; bus.jalr_new_pc = pc;
    step();
    bus.rs_has_output = 0;
  endtask

  task automatic lsb_bcast(input logic [3:0] id, input logic [31:0] val);
    bus.is_lsb = 1; bus.lsb_rob_id = id; bus.lsb_res = val;
    step();
    bus.is_lsb = 0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rdy_in = 1;
    #12;
    check("reset_rob_full", 32'(bus.rob_full), 32'd0);
    check("reset_tail_id", 32'(bus.rob_tail_id), 32'd0);
    check("reset_commit_valid", 32'(bus.commit_valid), 32'd0);
    check("reset_rob_clear", 32'(bus.rob_clear), 32'd0);
    check("reset_rob_new_pc", bus.rob_new_pc, 32'd0);
    @(posedge clk_in); #1 rst_in = 1;

    // Fill all 16 entries with no results.
    for (int i = 0; i < ROB_SIZE; i++) begin
      alloc(2'd0, 5'(i + 1), 1'b0, 32'd0);
      if (i == ROB_SIZE - 2) begin
        check("full_after_15", 32'(bus.rob_full), 32'd0);
        check("tail_after_15", 32'(bus.rob_tail_id), 32'd15);
      end
    end
    check("full_after_16", 32'(bus.rob_full), 32'd1);
    check("tail_wraps", 32'(bus.rob_tail_id), 32'd0);

    // Full ROB: commit head and alloc into the freed slot in the same cycle.
    expect_commit(4'd0, 5'd1, 32'hA0, 1, 0, 0, 32'd0);
    rs_bcast(4'd0, 32'hA0, 32'd0);
    alloc(2'd0, 5'd2, 1'b0, 32'd0);
    check("full_after_commit_alloc", 32'(bus.rob_full), 32'd1);
    check("tail_after_commit_alloc", 32'(bus.rob_tail_id), 32'd1);
    @(negedge clk_in); #1;

    // Reset mid-operation: everything discarded, pulses drop asynchronously.
    rst_in = 0;
    #2;
    check("midreset_full", 32'(bus.rob_full), 32'd0);
    check("midreset_tail", 32'(bus.rob_tail_id), 32'd0);
    check("midreset_commit_valid", 32'(bus.commit_valid), 32'd0);
    @(posedge clk_in); #1 rst_in = 1;

    // Single ALU result.
    alloc(2'd0, 5'd5, 1'b0, 32'd0);
    check("tail_after_one", 32'(bus.rob_tail_id), 32'd1);
    expect_commit(4'd0, 5'd5, 32'h1234, 1, 0, 0, 32'd0);
    rs_bcast(4'd0, 32'h1234, 32'd0);
    wait_cycles(3);

    // Out-of-order results, in-order commits; id4 is a store.
    alloc(2'd0, 5'd6, 1'b0, 32'd0);
    alloc(2'd0, 5'd7, 1'b0, 32'd0);
    alloc(2'd0, 5'd8, 1'b0, 32'd0);
    alloc(2'd3, 5'd9, 1'b0, 32'd0);
    expect_commit(4'd1, 5'd6, 32'h111, 1, 0, 0, 32'd0);
    expect_commit(4'd2, 5'd7, 32'h222, 1, 0, 0, 32'd0);
    expect_commit(4'd3, 5'd8, 32'h333, 1, 0, 0, 32'd0);
    expect_commit(4'd4, 5'd0, 32'd0, 0, 1, 0, 32'd0);
    bus.rs_has_output = 1; bus.rs_rob_id = 4'd3; bus.rs_output = 32'h333;
    bus.is_lsb = 1; bus.lsb_rob_id = 4'd4; bus.lsb_res = 32'd0;
    step();
    bus.rs_has_output = 0; bus.is_lsb = 0;
    bus.qry1_id = 4'd3; bus.qry2_id = 4'd4;
    #1;
    check("qry1_rdy_stored", 32'(bus.qry1_rdy), 32'd1);
    check("qry1_val_stored", bus.qry1_val, 32'h333);
    check("qry2_rdy_lsb", 32'(bus.qry2_rdy), 32'd1);
    rs_bcast(4'd2, 32'h222, 32'd0);
    lsb_bcast(4'd1, 32'h111);
    wait_cycles(6);

    // rdy_in=0 freezes commit and allocation.
    alloc(2'd0, 5'd10, 1'b0, 32'd0);
    rs_bcast(4'd5, 32'h500, 32'd0);
    rdy_in = 0;
    bus.dc_alloc = 1;
    step();
    check("stall_commit_valid_a", 32'(bus.commit_valid), 32'd0);
    step();
    check("stall_commit_valid_b", 32'(bus.commit_valid), 32'd0);
    check("stall_tail", 32'(bus.rob_tail_id), 32'd6);
    bus.dc_alloc = 0;
    expect_commit(4'd5, 5'd10, 32'h500, 1, 0, 0, 32'd0);
    rdy_in = 1;
    wait_cycles(3);

    // Query while the RS broadcasts to the same id.
    alloc(2'd0, 5'd11, 1'b0, 32'd0);
    bus.qry1_id = 4'd6; bus.qry2_id = 4'd7;
    bus.rs_has_output = 1; bus.rs_rob_id = 4'd6; bus.rs_output = 32'h55; bus.jalr_new_pc = 32'd0;
    #1;
`ifdef ROB_BYPASS_EN
    check("bypass_qry_rdy", 32'(bus.qry1_rdy), 32'd1);
    check("bypass_qry_val", bus.qry1_val, 32'h55);
`else
    check("nobypass_qry_rdy", 32'(bus.qry1_rdy), 32'd0);
`endif
    check("qry_idle_entry", 32'(bus.qry2_rdy), 32'd0);
    expect_commit(4'd6, 5'd11, 32'h55, 1, 0, 0, 32'd0);
    step();
    bus.rs_has_output = 0;
    #1;
    check("qry_rdy_next_cycle", 32'(bus.qry1_rdy), 32'd1);
    check("qry_val_next_cycle", bus.qry1_val, 32'h55);
    wait_cycles(3);

    // Branch mispredict flushes younger entries; alloc in the flush cycle is dropped.
    alloc(2'd1, 5'd3, 1'b0, 32'h44);
    alloc(2'd0, 5'd12, 1'b0, 32'd0);
    alloc(2'd0, 5'd13, 1'b0, 32'd0);
    rs_bcast(4'd8, 32'h88, 32'd0);
    expect_commit(4'd7, 5'd0, 32'd1, 1, 0, 1, 32'h80);
    rs_bcast(4'd7, 32'd1, 32'h80);
    alloc(2'd0, 5'd14, 1'b0, 32'd0);
    check("flush_tail", 32'(bus.rob_tail_id), 32'd0);
    check("flush_full", 32'(bus.rob_full), 32'd0);
    bus.qry1_id = 4'd8;
    #1;
    check("flush_discards_ready", 32'(bus.qry1_rdy), 32'd0);
    wait_cycles(4);

    // JALR: correct target commits quietly, wrong target redirects.
    alloc(2'd2, 5'd1, 1'b0, 32'h100);
    alloc(2'd2, 5'd2, 1'b0, 32'h200);
    expect_commit(4'd0, 5'd1, 32'h104, 1, 0, 0, 32'd0);
    rs_bcast(4'd0, 32'h104, 32'h100);
    expect_commit(4'd1, 5'd2, 32'h204, 1, 0, 1, 32'h300);
    rs_bcast(4'd1, 32'h204, 32'h300);
    wait_cycles(3);
    check("jalr_flush_tail", 32'(bus.rob_tail_id), 32'd0);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
